// File: rtl/data_mem_controller.sv
// data_mem_controller
//   Data-memory subsystem behind the Mem stage. It holds a word-wide
//   synchronous RAM and performs RV32I LB/LH/LW/LBU/LHU loads and SB/SH/SW
//   stores. Sub-word stores are done as a read-modify-write.
//
//   Handshake: the Mem stage raises memRead or memWrite together with
//   func3/addr/wData. It holds all of them stable until it samples ready=1
//   on a rising edge. ready=1 with no request pending means idle. ready=1
//   in DONE retires the request, and dOut/misalign are valid in that cycle.
//   The request must drop in that cycle. A request still present in DONE
//   is not started again.
//
// Ports
//   clk      system clock, rising edge
//   rstN     asynchronous active-low reset
//   memRead  load request
//   memWrite store request
//   func3    RV32I load/store access type
//   addr     byte address; bits above the word index are ignored
//   wData    store data; the low byte/half is used for SB/SH
//   dOut     registered, extended load result (0 after a fault)
//   ready    access complete, or no access pending (combinational)
//   misalign one-cycle pulse in DONE for a faulted access
module data_mem_controller #(
  parameter int DM_MEM_DEPTH = 4096,
  parameter int DATA_WIDTH   = 32,
  parameter int FUNC3_WIDTH  = 3
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   memRead,
  input  logic                   memWrite,
  input  logic [FUNC3_WIDTH-1:0] func3,
  input  logic [DATA_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  wData,
  output logic [DATA_WIDTH-1:0]  dOut,
  output logic                   ready,
  output logic                   misalign
);

  localparam int IDX_W = $clog2(DM_MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW, DONE} stateT;

  stateT state;

  logic [DATA_WIDTH-1:0] mem [DM_MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ramQ;
  logic [IDX_W-1:0]      wordIdx;
  logic                  ramWe;
  logic [DATA_WIDTH-1:0] ramWData;

  logic                  halfOk, wordOk;
  logic                  validLoad, validSw, validSub, fault;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] laneWord, loadData;
  logic [DATA_WIDTH-1:0] mergeMask, mergeData, mergedWord;

  // The address wraps modulo the RAM depth, so the upper address bits are
  // deliberately unused.
  logic unusedAddrBits;
  assign unusedAddrBits = ^addr[DATA_WIDTH-1:IDX_W+2];

  assign wordIdx = addr[IDX_W+1:2];
  assign shamt   = {addr[1:0], 3'b000};

  // Request decode. Anything not recognised as a legal, aligned access
  // becomes a fault, and so does a simultaneous read and write.
  always_comb begin
    halfOk    = ~addr[0];
    wordOk    = (addr[1:0] == 2'b00);
    validLoad = 1'b0;
    validSw   = 1'b0;
    validSub  = 1'b0;
    if (memRead && !memWrite) begin
      case (func3)
        3'b000, 3'b100: validLoad = 1'b1;
        3'b001, 3'b101: validLoad = halfOk;
        3'b010:         validLoad = wordOk;
        default:        validLoad = 1'b0;
      endcase
    end
    if (memWrite && !memRead) begin
      case (func3)
        3'b000:  validSub = 1'b1;
        3'b001:  validSub = halfOk;
        3'b010:  validSw  = wordOk;
        default: validSub = 1'b0;
      endcase
    end
    fault = (memRead || memWrite) && !(validLoad || validSw || validSub);
  end

  // Lane extraction from the RAM word that was read during the IDLE cycle.
  always_comb begin
    laneWord = ramQ >> shamt;
    case (func3)
      3'b000:  loadData = {{24{laneWord[7]}}, laneWord[7:0]};
      3'b001:  loadData = {{16{laneWord[15]}}, laneWord[15:0]};
      3'b100:  loadData = {24'h0, laneWord[7:0]};
      3'b101:  loadData = {16'h0, laneWord[15:0]};
      default: loadData = ramQ;
    endcase
  end

  // Sub-word merge for the RMW write-back.
  always_comb begin
    if (func3 == 3'b001) begin
      mergeMask = 32'h0000_FFFF << shamt;
      mergeData = {16'h0, wData[15:0]} << shamt;
    end else begin
      mergeMask = 32'h0000_00FF << shamt;
      mergeData = {24'h0, wData[7:0]} << shamt;
    end
    mergedWord = (ramQ & ~mergeMask) | (mergeData & mergeMask);
  end

  // RAM write port. Writes are gated by rstN so that a store held during
  // reset, or an RMW cut short by reset, never reaches the array.
  always_comb begin
    ramWe    = 1'b0;
    ramWData = wData;
    if (rstN) begin
      if (state == IDLE && validSw) begin
        ramWe    = 1'b1;
        ramWData = wData;
      end else if (state == RMW) begin
        ramWe    = 1'b1;
        ramWData = mergedWord;
      end
    end
  end

  // The RAM has no reset. The word is read every cycle, so ramQ holds the
  // word addressed in the previous cycle.
  always_ff @(posedge clk) begin
    if (ramWe) mem[wordIdx] <= ramWData;
    ramQ <= mem[wordIdx];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      dOut     <= '0;
      misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          misalign <= 1'b0;
          if (fault) begin
            dOut     <= '0;
            misalign <= 1'b1;
            state    <= DONE;
          end else if (validLoad) begin
            state <= RD_WAIT;
          end else if (validSw) begin
            state <= DONE;
          end else if (validSub) begin
            state <= RMW;
          end
        end
        RD_WAIT: begin
          dOut  <= loadData;
          state <= DONE;
        end
        RMW: begin
          state <= DONE;
        end
        DONE: begin
          misalign <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          misalign <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign ready = (state == IDLE && !memRead && !memWrite) || (state == DONE);

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller. A byte-addressed reference
// memory supplies the expected load data, latency and fault behaviour.
module tb_data_mem_controller;

  logic        clk;
  logic        rstN;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wData;
  logic [31:0] dOut;
  logic        ready;
  logic        misalign;

  int nVectors;
  int nMiscompares;

  // Reference memory: 4096 words = 16 KiB, indexed by addr[13:0].
  logic [7:0]  refMem [0:16383];
  logic [31:0] lastDout;

  data_mem_controller #(.DM_MEM_DEPTH(4096), .DATA_WIDTH(32), .FUNC3_WIDTH(3)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .memRead  (memRead),
    .memWrite (memWrite),
    .func3    (func3),
    .addr     (addr),
    .wData    (wData),
    .dOut     (dOut),
    .ready    (ready),
    .misalign (misalign)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic logic isFault(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (!rd && !wr) return 1'b0;
    if (f3 == 3'd0 || (rd && f3 == 3'd4)) return 1'b0;
    if (f3 == 3'd1 || (rd && f3 == 3'd5)) return a[0];
    if (f3 == 3'd2) return (a[1:0] != 2'b00);
    return 1'b1;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] a);
    logic [13:0] b;
    logic [7:0]  b0, b1;
    b  = a[13:0];
    b0 = refMem[b];
    b1 = refMem[b + 14'd1];
    case (f3)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd1:    return {{16{b1[7]}}, b1, b0};
      3'd4:    return {24'h0, b0};
      3'd5:    return {16'h0, b1, b0};
      default: return {refMem[b + 14'd3], refMem[b + 14'd2], b1, b0};
    endcase
  endfunction

  task automatic refStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [13:0] b;
    int nBytes;
    b = a[13:0];
    nBytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int k = 0; k < nBytes; k++) refMem[b + 14'(k)] = wd[8*k +: 8];
  endtask

  // Driver: one full request/retire handshake, fully checked.
  task automatic doAccess(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic        flt;
    int          expLat;
    int          lat;
    logic [31:0] expD;
    flt    = isFault(rd, wr, f3, a);
    expLat = flt ? 1 : rd ? 2 : (f3 == 3'd2) ? 1 : 2;
    expD   = flt ? 32'h0 : rd ? refLoad(f3, a) : lastDout;

    @(negedge clk);
    memRead  = rd;
    memWrite = wr;
    func3    = f3;
    addr     = a;
    wData    = wd;
    #1;
    check({tag, "_busy"}, {31'h0, ready}, 32'h0);

    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ready && lat < 8);
    check({tag, "_lat"}, lat, expLat);
    check({tag, "_dout"}, dOut, expD);
    check({tag, "_mis"}, {31'h0, misalign}, {31'h0, flt});

    if (wr && !rd && !flt) refStore(f3, a, wd);
    lastDout = expD;
    memRead  = 1'b0;
    memWrite = 1'b0;

    @(posedge clk);
    #1;
    check({tag, "_idleRdy"}, {31'h0, ready}, 32'h1);
    check({tag, "_idleMis"}, {31'h0, misalign}, 32'h0);
    check({tag, "_hold"}, dOut, expD);
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    lastDout     = 32'h0;
    rstN     = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    func3    = 3'd0;
    addr     = 32'h0;
    wData    = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, ready}, 32'h1);
    check("rst_dout", dOut, 32'h0);
    check("rst_mis", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Idle with no request
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("idle_ready", {31'h0, ready}, 32'h1);
      check("idle_dout", dOut, 32'h0);
      check("idle_mis", {31'h0, misalign}, 32'h0);
    end

    // Preload a 256-byte region so every model read is defined.
    for (int i = 0; i < 64; i++)
      doAccess(1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom, "init_sw");

    // Directed sequence
    doAccess(1'b0, 1'b1, 3'd2, 32'h10, 32'h11223344, "sw10");
    doAccess(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "lw10a");
    check("lw10a_lit", dOut, 32'h11223344);
    doAccess(1'b0, 1'b1, 3'd0, 32'h11, 32'h000000AB, "sb11");
    doAccess(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "lw10b");
    check("lw10b_lit", dOut, 32'h1122AB44);
    doAccess(1'b1, 1'b0, 3'd0, 32'h11, 32'h0, "lb11");
    check("lb11_lit", dOut, 32'hFFFFFFAB);
    doAccess(1'b1, 1'b0, 3'd4, 32'h11, 32'h0, "lbu11");
    check("lbu11_lit", dOut, 32'h000000AB);
    doAccess(1'b0, 1'b1, 3'd1, 32'h12, 32'h0000BEEF, "sh12");
    doAccess(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "lw10c");
    check("lw10c_lit", dOut, 32'hBEEFAB44);
    doAccess(1'b1, 1'b0, 3'd1, 32'h12, 32'h0, "lh12");
    check("lh12_lit", dOut, 32'hFFFFBEEF);
    doAccess(1'b1, 1'b0, 3'd5, 32'h12, 32'h0, "lhu12");
    check("lhu12_lit", dOut, 32'h0000BEEF);

    // Faults
    doAccess(1'b1, 1'b0, 3'd2, 32'h13, 32'h0, "flt_lw13");
    doAccess(1'b0, 1'b1, 3'd1, 32'h11, 32'h5555, "flt_sh11");
    doAccess(1'b0, 1'b1, 3'd3, 32'h10, 32'h7777, "flt_f3");
    doAccess(1'b1, 1'b1, 3'd2, 32'h10, 32'h9999, "flt_both");
    doAccess(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "lw10d");
    check("lw10d_lit", dOut, 32'hBEEFAB44);

    // Reset in the middle of an RMW
    @(negedge clk);
    memWrite = 1'b1;
    func3    = 3'd0;
    addr     = 32'h10;
    wData    = 32'h000000FF;
    @(posedge clk);
    #1;
    check("rmw_busy", {31'h0, ready}, 32'h0);
    #2;
    rstN = 1'b0;
    #1;
    check("rmwrst_ready", {31'h0, ready}, 32'h0);
    check("rmwrst_dout", dOut, 32'h0);
    check("rmwrst_mis", {31'h0, misalign}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rmwrst_ready2", {31'h0, ready}, 32'h0);
    memWrite = 1'b0;
    @(negedge clk);
    rstN     = 1'b1;
    lastDout = 32'h0;
    #1;
    check("rstrel_ready", {31'h0, ready}, 32'h1);
    doAccess(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "lw10e");
    check("lw10e_lit", dOut, 32'hBEEFAB44);

    // Address aliasing modulo the RAM depth
    doAccess(1'b0, 1'b1, 3'd2, 32'h4010, 32'hCAFEF00D, "sw4010");
    doAccess(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "lw10alias");
    check("alias_lit", dOut, 32'hCAFEF00D);

    // Randomized traffic inside the preloaded region, random upper bits.
    for (int i = 0; i < 300; i++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int          kind;
      kind = $urandom_range(0, 9);
      rd   = (kind < 5) || (kind == 9);
      wr   = (kind >= 5);
      f3   = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      if (rd && !wr && $urandom_range(0, 3) == 0) f3 = 3'($urandom_range(4, 5));
      a    = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 255));
      doAccess(rd, wr, f3, a, $urandom, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
